bus_interconnect: RTL

Parametrised address-decoding interconnect between the CPU data-bus master and NUM_SLAVES memory-mapped slaves (main RAM, peripherals). It replaces the direct CPU-to-RAM wiring with a registered request/ready handshake and variable slave latency. Unmapped addresses and slave timeouts return a bus error. Exactly one transaction is outstanding at a time.

---
 rtl/bus_interconnect_pkg.sv | 26 ++
 rtl/bus_interconnect_bus_addr_decoder.sv | 28 ++
 rtl/bus_interconnect.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bus_interconnect_pkg.sv
// Shared definitions for the CPU data-bus interconnect: FSM states, default
// memory map, error data and the CPU/RAM write-length encodings.
package bus_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_t;

  localparam logic [31:0]  DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;

  // Slave i lives at bits [32*i+31:32*i]: slave0 at 0x0000_0000 ... slave3 at 0x3000_0000
  localparam logic [127:0] DEFAULT_SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                 32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] DEFAULT_SLAVE_MASK = {4{32'hF000_0000}};

  localparam logic [2:0] WLEN_BYTE = 3'b000;
  localparam logic [2:0] WLEN_HALF = 3'b001;
  localparam logic [2:0] WLEN_WORD = 3'b010;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_interconnect_bus_addr_decoder.sv
// Combinational address decoder: reports whether any slave window matches and
// the index of the lowest-numbered matching slave.
module bus_addr_decoder
  import bus_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [31:0]              address,
  input  logic [32*NUM_SLAVES-1:0] slave_base,
  input  logic [32*NUM_SLAVES-1:0] slave_mask,
  output logic                     match,
  output logic [SEL_W-1:0]         sel
);

  // Walk from the top down so the lowest matching index is written last
  always_comb begin
    match = 1'b0;
    sel   = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((address & slave_mask[32*i +: 32]) == slave_base[32*i +: 32]) begin
        match = 1'b1;
        sel   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-outstanding request/ready interconnect between the CPU data-bus master
// and NUM_SLAVES memory-mapped slaves, with unmapped-address and timeout errors.
module bus_interconnect
  import bus_interconnect_pkg::*;
#(
  parameter int                          NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_BASE     = DEFAULT_SLAVE_BASE,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_MASK     = DEFAULT_SLAVE_MASK,
  parameter int                          TIMEOUT_CYCLES = 16,
  parameter logic [31:0]                 ERROR_DATA     = DEFAULT_ERROR_DATA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_m_valid,
  input  logic [31:0]              i_m_address,
  input  logic [31:0]              i_m_wr_data,
  input  logic                     i_m_wr_enable,
  input  logic [2:0]               i_m_write_length,
  output logic                     o_m_ready,
  output logic [31:0]              o_m_read_data,
  output logic                     o_m_error,
  output logic [NUM_SLAVES-1:0]    o_s_valid,
  output logic [31:0]              o_s_address,
  output logic [31:0]              o_s_wr_data,
  output logic                     o_s_wr_enable,
  output logic [2:0]               o_s_write_length,
  input  logic [NUM_SLAVES-1:0]    i_s_ready,
  input  logic [32*NUM_SLAVES-1:0] i_s_read_data
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  bus_state_t        state, state_nxt;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt;
  logic              dec_match;
  logic [SEL_W-1:0]  dec_sel;
  logic              slave_rdy;
  logic              timeout;
  logic [31:0]       s_rdata [NUM_SLAVES];

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .address    (i_m_address),
    .slave_base (SLAVE_BASE),
    .slave_mask (SLAVE_MASK),
    .match      (dec_match),
    .sel        (dec_sel)
  );

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
    assign s_rdata[g] = i_s_read_data[32*g +: 32];
  end

  assign slave_rdy = i_s_ready[sel_q];
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_m_ready = (state == ST_RESP);

  always_comb begin
    o_s_valid = '0;
    if (state == ST_ACCESS) o_s_valid[sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_m_valid) state_nxt = dec_match ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (slave_rdy || timeout) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, response capture and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q            <= '0;
      cnt              <= '0;
      o_s_address      <= '0;
      o_s_wr_data      <= '0;
      o_s_wr_enable    <= 1'b0;
      o_s_write_length <= '0;
      o_m_read_data    <= '0;
      o_m_error        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_m_valid) begin
            o_s_address      <= i_m_address;
            o_s_wr_data      <= i_m_wr_data;
            o_s_wr_enable    <= i_m_wr_enable;
            o_s_write_length <= i_m_write_length;
            sel_q            <= dec_sel;
            if (!dec_match) begin
              o_m_error     <= 1'b1;
              o_m_read_data <= ERROR_DATA;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          // A slave answering on the final allowed cycle still beats the timeout
          if (slave_rdy) begin
            o_m_read_data <= s_rdata[sel_q];
            o_m_error     <= 1'b0;
          end else if (timeout) begin
            o_m_read_data <= ERROR_DATA;
            o_m_error     <= 1'b1;
          end
        end
        ST_RESP: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule
